// File: rtl/ifft4_stream_pkg.sv
// Shared types and widths for the 4-point inverse DFT stream engine.
// The sum width leaves two bits of headroom so negating -2^(W-1) is exact.
package ifft4_stream_pkg;

    localparam int W  = 16;
    localparam int WE = W + 2;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Quarter-turn code: the value is rotated by j^q.
    typedef logic [1:0] qturn_t;

endpackage

// File: rtl/ifft4_stream_if.sv
// Sample stream bundle for ifft4_stream: one complex input port and one complex output port.
// A transfer happens on a rising edge where valid && ready; the sender holds data stable while valid && !ready.
interface ifft4_stream_if #(
    parameter int W = ifft4_stream_pkg::W
);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] INar;
    logic signed [W-1:0] INai;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] OUTar;
    logic signed [W-1:0] OUTai;
    logic [1:0]          out_idx;
    logic                out_last;

    modport master (
        output in_valid, INar, INai, out_ready,
        input  in_ready, out_valid, OUTar, OUTai, out_idx, out_last
    );

    modport slave (
        input  in_valid, INar, INai, out_ready,
        output in_ready, out_valid, OUTar, OUTai, out_idx, out_last
    );

endinterface

// File: rtl/ifft4_stream_cplx_qrot.sv
// Combinational multiply of a complex value by j^q using only swaps and negations.
// Operands arrive already widened, so the negation never overflows.
module cplx_qrot
    import ifft4_stream_pkg::*;
#(
    parameter int WX = WE
) (
    input  logic signed [WX-1:0] a_re,
    input  logic signed [WX-1:0] a_im,
    input  qturn_t               q,
    output logic signed [WX-1:0] r_re,
    output logic signed [WX-1:0] r_im
);

    always_comb begin
        r_re = a_re;
        r_im = a_im;
        unique case (q)
            2'd0: begin
                r_re = a_re;
                r_im = a_im;
            end
            2'd1: begin
                r_re = -a_im;
                r_im = a_re;
            end
            2'd2: begin
                r_re = -a_re;
                r_im = -a_im;
            end
            default: begin
                r_re = a_im;
                r_im = -a_re;
            end
        endcase
    end

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse DFT: collects four samples, then emits y[n] = (1/4) sum X[k] (+j)^(nk).
// Each output is computed from the buffer just before it is presented, so only one summing tree exists.
module ifft4_stream
    import ifft4_stream_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ifft4_stream_if.slave   bus,
    output state_t          dbg_state
);

    state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       wr_en;
    logic       load_out;
    logic [1:0] n_sel;

    logic signed [W-1:0]  buf_re [4];
    logic signed [W-1:0]  buf_im [4];
    logic signed [WE-1:0] x_re   [4];
    logic signed [WE-1:0] x_im   [4];
    logic signed [WE-1:0] t_re   [4];
    logic signed [WE-1:0] t_im   [4];
    qturn_t               q      [4];
    logic signed [WE-1:0] sum_re, sum_im;
    logic signed [W-1:0]  y_re, y_im;

    // The final sample of a frame is bypassed from the port so y[0] is ready on the accepting edge.
    for (genvar k = 0; k < 4; k++) begin : g_term
        assign x_re[k] = (state == LOAD && cnt == 2'(k))
                         ? {{2{bus.INar[W-1]}}, bus.INar} : {{2{buf_re[k][W-1]}}, buf_re[k]};
        assign x_im[k] = (state == LOAD && cnt == 2'(k))
                         ? {{2{bus.INai[W-1]}}, bus.INai} : {{2{buf_im[k][W-1]}}, buf_im[k]};
        assign q[k]    = n_sel * 2'(k);

        cplx_qrot #(.WX(WE)) u_rot (
            .a_re (x_re[k]),
            .a_im (x_im[k]),
            .q    (q[k]),
            .r_re (t_re[k]),
            .r_im (t_im[k])
        );
    end

    assign sum_re = t_re[0] + t_re[1] + t_re[2] + t_re[3];
    assign sum_im = t_im[0] + t_im[1] + t_im[2] + t_im[3];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wr_en    = 1'b0;
        load_out = 1'b0;
        n_sel    = 2'd0;
        unique case (state)
            LOAD: begin
                n_sel = 2'd0;
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_n  = DRAIN;
                        load_out = 1'b1;
                        cnt_n    = 2'd0;
                    end
                end
            end
            default: begin
                n_sel = cnt + 2'd1;
                if (bus.out_ready) begin
                    if (cnt == 2'd3) begin
                        state_n = LOAD;
                        cnt_n   = 2'd0;
                    end else begin
                        load_out = 1'b1;
                        cnt_n    = cnt + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= 2'd0;
            y_re  <= '0;
            y_im  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load_out) begin
                // Floor divide by 4; the range of the sum guarantees the result fits in W bits.
                y_re <= sum_re[W+1:2];
                y_im <= sum_im[W+1:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_re[cnt] <= bus.INar;
            buf_im[cnt] <= bus.INai;
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_idx   = (state == DRAIN) ? cnt : 2'd0;
    assign bus.out_last  = (state == DRAIN) && (cnt == 2'd3);
    assign bus.OUTar     = y_re;
    assign bus.OUTai     = y_im;
    assign dbg_state     = state;

endmodule

// File: tb/tb_ifft4_stream.sv
// Directed bench for ifft4_stream: hand-computed frames, backpressure, back-to-back and reset cases.
// Expected outputs are packed as {idx, last, re, im} and queued before each frame is sent.
module tb_ifft4_stream;
    import ifft4_stream_pkg::*;

    localparam int EW = 2 * W + 3;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    always #5 clk = ~clk;

    ifft4_stream_if #(.W(W)) bus ();

    ifft4_stream dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got[4];
    int            f_re[4];
    int            f_im[4];

    function automatic logic [EW-1:0] mk(int n, int re, int im);
        logic [EW-1:0] v;
        v = {n[1:0], (n == 3), re[W-1:0], im[W-1:0]};
        return v;
    endfunction

    task automatic send_sample(input int re, input int im);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.INar     = re[W-1:0];
        bus.INai     = im[W-1:0];
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 4; i++) send_sample(f_re[i], f_im[i]);
    endtask

    task automatic collect(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            @(negedge clk);
            bus.out_ready = 1'b1;
            while (bus.out_valid !== 1'b1 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) begin
                checks++;
                errors++;
                $display("FAIL collect_timeout out_valid=%b required 1", bus.out_valid);
                got[i] = 'x;
            end else begin
                got[i] = {bus.out_idx, bus.out_last, bus.OUTar, bus.OUTai};
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [EW-1:0] exp;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp = mk(0, 0, 0);
        checks++;
        if ({bus.out_idx, 1'b0, bus.OUTar, bus.OUTai} !== exp || bus.out_last !== 1'b0
            || bus.out_valid !== 1'b0 || dbg_state !== LOAD) begin
            errors++;
            $display("FAIL reset_values got idx=%0d last=%b re=%0d im=%0d valid=%b state=%0d required all zero, LOAD",
                     bus.out_idx, bus.out_last, bus.OUTar, bus.OUTai, bus.out_valid, dbg_state);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_impulse();
        logic [EW-1:0] exp;
        for (int n = 0; n < 4; n++) exp_q.push_back(mk(n, 1, 0));
        f_re = '{4, 0, 0, 0};
        f_im = '{0, 0, 0, 0};
        send_frame();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL impulse_latency got out_valid=%b in_ready=%b required 1 0", bus.out_valid, bus.in_ready);
        end
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL impulse y[%0d] got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_single_bin();
        logic [EW-1:0] exp;
        exp_q.push_back(mk(0, 1, 0));
        exp_q.push_back(mk(1, 0, 1));
        exp_q.push_back(mk(2, -1, 0));
        exp_q.push_back(mk(3, 0, -1));
        f_re = '{0, 4, 0, 0};
        f_im = '{0, 0, 0, 0};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL single_bin y[%0d] got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_dc();
        logic [EW-1:0] exp;
        exp_q.push_back(mk(0, 4, 4));
        for (int n = 1; n < 4; n++) exp_q.push_back(mk(n, 0, 0));
        f_re = '{4, 4, 4, 4};
        f_im = '{4, 4, 4, 4};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL dc y[%0d] got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_extremes();
        logic [EW-1:0] exp;
        exp_q.push_back(mk(0, -1, -1));
        exp_q.push_back(mk(1, 32767, 0));
        exp_q.push_back(mk(2, -1, 0));
        exp_q.push_back(mk(3, 0, 0));
        f_re = '{32767, 0, -32768, 0};
        f_im = '{0, -32768, 0, 32767};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL extremes_a y[%0d] got %h required %h", i, got[i], exp);
            end
        end
        exp_q.push_back(mk(0, -32768, -32768));
        for (int n = 1; n < 4; n++) exp_q.push_back(mk(n, 0, 0));
        f_re = '{-32768, -32768, -32768, -32768};
        f_im = '{-32768, -32768, -32768, -32768};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL extremes_b y[%0d] got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_floor();
        logic [EW-1:0] exp;
        // (-1-1j)/4 must round toward minus infinity on every output.
        for (int n = 0; n < 4; n++) exp_q.push_back(mk(n, -1, -1));
        f_re = '{-1, 0, 0, 0};
        f_im = '{-1, 0, 0, 0};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL floor y[%0d] got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] exp;
        logic [EW-1:0] obs;
        exp_q.push_back(mk(0, 2, 2));
        exp_q.push_back(mk(1, 8, 2));
        exp_q.push_back(mk(2, 0, 0));
        exp_q.push_back(mk(3, -2, 0));
        f_re = '{8, 4, -4, 0};
        f_im = '{4, -8, 0, 12};
        send_frame();
        collect(1);
        exp = exp_q.pop_front();
        checks++;
        if (got[0] !== exp) begin
            errors++;
            $display("FAIL backpressure y[0] got %h required %h", got[0], exp);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = ((c % 2) == 0);
            bus.INar     = 16'sh7fff;
            bus.INai     = 16'sh1234;
            @(negedge clk);
            obs = {bus.out_idx, bus.out_last, bus.OUTar, bus.OUTai};
            checks++;
            if (obs !== exp_q[0] || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold c=%0d got %h in_ready=%b out_valid=%b required %h 0 1",
                         c, obs, bus.in_ready, bus.out_valid, exp_q[0]);
            end
        end
        bus.in_valid = 1'b0;
        collect(3);
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL backpressure y[%0d] got %h required %h", i + 1, got[i], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] exp;
        for (int n = 0; n < 4; n++) exp_q.push_back(mk(n, 1, 0));
        f_re = '{4, 0, 0, 0};
        f_im = '{0, 0, 0, 0};
        send_frame();
        collect(4);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_turnaround got in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL b2b_first y[%0d] got %h required %h", i, got[i], exp);
            end
        end
        exp_q.push_back(mk(0, 1, 0));
        exp_q.push_back(mk(1, 0, 1));
        exp_q.push_back(mk(2, -1, 0));
        exp_q.push_back(mk(3, 0, -1));
        f_re = '{0, 4, 0, 0};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL b2b_second y[%0d] got %h required %h", i, got[i], exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [EW-1:0] exp;
        send_sample(100, 200);
        send_sample(-300, 400);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== LOAD) begin
            errors++;
            $display("FAIL reset_in_load got out_valid=%b in_ready=%b state=%0d required 0 1 LOAD",
                     bus.out_valid, bus.in_ready, dbg_state);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(0, 2, 0));
        exp_q.push_back(mk(1, -2, 0));
        exp_q.push_back(mk(2, 2, 0));
        exp_q.push_back(mk(3, -2, 0));
        f_re = '{0, 0, 8, 0};
        f_im = '{0, 0, 0, 0};
        send_frame();
        collect(4);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("FAIL reset_refill y[%0d] got %h required %h", i, got[i], exp);
            end
        end
        f_re = '{4, 4, 4, 4};
        f_im = '{4, 4, 4, 4};
        send_frame();
        collect(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.OUTar !== 16'sd0 || bus.OUTai !== 16'sd0
            || bus.out_last !== 1'b0 || bus.out_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_in_drain got valid=%b re=%0d im=%0d last=%b idx=%0d required all zero",
                     bus.out_valid, bus.OUTar, bus.OUTai, bus.out_last, bus.out_idx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.INar      = '0;
        bus.INai      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_single_bin();
        test_dc();
        test_extremes();
        test_floor();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
